// File: rtl/ctrl_pipe.sv
// ctrl_pipe: control-bundle pipeline with per-stage valid, stall/flush, bubble counter and stall-ordering flag
module ctrl_pipe #(
  parameter int STAGES = 3,
  parameter int WIDTH = 14,
  parameter int ZERO_INVALID = 1,
  parameter int CNT_W = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [WIDTH-1:0]          in_data,
  input  logic                      in_valid,
  input  logic                      stall_in,
  input  logic [STAGES-1:0]         stall,
  input  logic [STAGES-1:0]         flush,
  input  logic                      flush_all,
  input  logic                      clr_cnt,
  output logic [STAGES*WIDTH-1:0]   out_data,
  output logic [STAGES-1:0]         out_valid,
  output logic [CNT_W-1:0]          bubble_cnt,
  output logic                      order_err
);
  logic [STAGES*WIDTH-1:0] dataNext, srcData;
  logic [STAGES-1:0] validNext, srcValid, upStall;
  logic bubble, orderSet;
  assign bubble = stall_in & ~stall[0] & ~flush[0] & ~flush_all;
  assign orderSet = ((|(~stall & (stall >> 1) & ~flush)) & ~flush_all) | (~stall_in & stall[0] & in_valid);
  // Per-stage next state: flush beats stall, stall holds, stalled upstream injects a bubble, else shift
  always_comb begin
    srcData = out_data << WIDTH;
    srcData[WIDTH-1:0] = in_data;
    srcValid = out_valid << 1;
    srcValid[0] = in_valid;
    upStall = stall << 1;
    upStall[0] = stall_in;
    dataNext = out_data;
    validNext = out_valid;
    for (int i = 0; i < STAGES; i++) begin
      if (flush_all || flush[i]) begin
        dataNext[i*WIDTH +: WIDTH] = '0;
        validNext[i] = 1'b0;
      end else if (!stall[i]) begin
        validNext[i] = upStall[i] ? 1'b0 : srcValid[i];
        dataNext[i*WIDTH +: WIDTH] = (upStall[i] || (ZERO_INVALID != 0 && !srcValid[i])) ? '0 : srcData[i*WIDTH +: WIDTH];
      end
    end
  end
  // Stage registers
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      out_data <= '0;
      out_valid <= '0;
    end else begin
      out_data <= dataNext;
      out_valid <= validNext;
    end
  // Saturating bubble counter and sticky ordering flag; clear wins over set/increment
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      bubble_cnt <= '0;
      order_err <= 1'b0;
    end else if (clr_cnt) begin
      bubble_cnt <= '0;
      order_err <= 1'b0;
    end else begin
      if (bubble && !(&bubble_cnt)) bubble_cnt <= bubble_cnt + CNT_W'(1);
      if (orderSet) order_err <= 1'b1;
    end
endmodule

// File: tb/tb_ctrl_pipe.sv
// tb_ctrl_pipe: directed and random checks of ctrl_pipe against a stage-array reference model
module tb_ctrl_pipe;
  logic clk = 0, rst = 1;
  logic [13:0] in_data = '0;
  logic in_valid = 0, stall_in = 0, flush_all = 0, clr_cnt = 0;
  logic [2:0] stall = '0, flush = '0;
  logic [41:0] outA, outB;
  logic [2:0] validA, validB;
  logic [15:0] cntA;
  logic [1:0] cntB;
  logic errA, errB;
  int passed = 0, total = 0;
  logic [13:0] mZ [3];
  logic [13:0] mR [3];
  bit mV [3];
  int mCntA, mCntB;
  bit mErr;

  always #5 clk = ~clk;

  ctrl_pipe dutA (.clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .stall_in(stall_in),
    .stall(stall), .flush(flush), .flush_all(flush_all), .clr_cnt(clr_cnt),
    .out_data(outA), .out_valid(validA), .bubble_cnt(cntA), .order_err(errA));
  ctrl_pipe #(.ZERO_INVALID(0), .CNT_W(2)) dutB (.clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .stall_in(stall_in), .stall(stall), .flush(flush), .flush_all(flush_all), .clr_cnt(clr_cnt),
    .out_data(outB), .out_valid(validB), .bubble_cnt(cntB), .order_err(errB));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic modelReset();
    for (int i = 0; i < 3; i++) begin mZ[i] = '0; mR[i] = '0; mV[i] = 0; end
    mCntA = 0; mCntB = 0; mErr = 0;
  endtask

  task automatic modelStep();
    logic [13:0] nZ [3];
    logic [13:0] nR [3];
    bit nV [3];
    bit up, sv, setErr, bub;
    logic [13:0] sz, sr;
    for (int i = 0; i < 3; i++) begin
      up = (i == 0) ? stall_in : stall[i-1];
      sv = (i == 0) ? in_valid : mV[i-1];
      sz = (i == 0) ? in_data : mZ[i-1];
      sr = (i == 0) ? in_data : mR[i-1];
      if (flush_all || flush[i]) begin nZ[i] = 0; nR[i] = 0; nV[i] = 0; end
      else if (stall[i]) begin nZ[i] = mZ[i]; nR[i] = mR[i]; nV[i] = mV[i]; end
      else if (up) begin nZ[i] = 0; nR[i] = 0; nV[i] = 0; end
      else begin nV[i] = sv; nZ[i] = sv ? sz : 14'h0; nR[i] = sr; end
    end
    bub = stall_in && !stall[0] && !flush[0] && !flush_all;
    setErr = (!stall_in && stall[0] && in_valid);
    for (int i = 0; i < 2; i++)
      if (!stall[i] && stall[i+1] && !flush[i] && !flush_all) setErr = 1;
    if (clr_cnt) begin mCntA = 0; mCntB = 0; mErr = 0; end
    else begin
      if (bub) begin mCntA = (mCntA == 65535) ? 65535 : mCntA + 1; mCntB = (mCntB == 3) ? 3 : mCntB + 1; end
      mErr = mErr | setErr;
    end
    for (int i = 0; i < 3; i++) begin mZ[i] = nZ[i]; mR[i] = nR[i]; mV[i] = nV[i]; end
  endtask

  task automatic cmpAll(input string tag);
    logic [2:0] ev;
    for (int i = 0; i < 3; i++) begin
      ev[i] = mV[i];
      chk($sformatf("%s A.data%0d", tag, i), 32'(outA[i*14 +: 14]), 32'(mZ[i]));
      chk($sformatf("%s B.data%0d", tag, i), 32'(outB[i*14 +: 14]), 32'(mR[i]));
    end
    chk({tag, " A.valid"}, 32'(validA), 32'(ev));
    chk({tag, " B.valid"}, 32'(validB), 32'(ev));
    chk({tag, " A.cnt"}, 32'(cntA), mCntA);
    chk({tag, " B.cnt"}, 32'(cntB), mCntB);
    chk({tag, " A.err"}, 32'(errA), 32'(mErr));
    chk({tag, " B.err"}, 32'(errB), 32'(mErr));
  endtask

  task automatic tick(input string tag);
    modelStep();
    @(posedge clk);
    #1;
    cmpAll(tag);
  endtask

  task automatic idle();
    in_valid = 0; in_data = '0; stall_in = 0; stall = '0; flush = '0; flush_all = 0; clr_cnt = 0;
  endtask

  initial begin
    modelReset();
    #3;
    chk("reset data", 32'(outA), 0);
    chk("reset valid", 32'(validA), 0);
    chk("reset cnt", 32'(cntA), 0);
    chk("reset err", 32'(errA), 0);
    @(negedge clk);
    rst = 0;
    // flow
    in_valid = 1;
    in_data = 14'h1A5; tick("flow1");
    in_data = 14'h2B6; tick("flow2");
    in_data = 14'h3C7; tick("flow3");
    chk("flow s0", 32'(outA[13:0]), 32'h3C7);
    chk("flow s1", 32'(outA[27:14]), 32'h2B6);
    chk("flow s2", 32'(outA[41:28]), 32'h1A5);
    chk("flow valid", 32'(validA), 32'h7);
    chk("flow cnt", 32'(cntA), 0);
    // stall and bubble
    in_valid = 0; stall_in = 1; stall = 3'b001;
    tick("stall1");
    chk("stall1 s0", 32'(outA[13:0]), 32'h3C7);
    chk("stall1 s1 valid", 32'(validA[1]), 0);
    tick("stall2");
    chk("stall2 s0", 32'(outA[13:0]), 32'h3C7);
    stall = 3'b000;
    tick("bubble");
    chk("bubble s0 data", 32'(outA[13:0]), 0);
    chk("bubble s0 valid", 32'(validA[0]), 0);
    chk("bubble cnt", 32'(cntA), 1);
    chk("bubble err", 32'(errA), 0);
    // flush beats stall
    idle(); in_valid = 1;
    in_data = 14'h0FF; tick("fill1");
    in_data = 14'h011; tick("fill2");
    chk("fill s1", 32'(outA[27:14]), 32'h0FF);
    stall = 3'b010; flush = 3'b010;
    tick("flushpri");
    chk("flushpri s1 data", 32'(outA[27:14]), 0);
    chk("flushpri s1 valid", 32'(validA[1]), 0);
    idle(); in_valid = 1; in_data = 14'h123;
    tick("refill1"); tick("refill2"); tick("refill3");
    idle(); flush_all = 1;
    tick("flushall");
    chk("flushall data", 32'(outA), 0);
    chk("flushall valid", 32'(validA), 0);
    // zero-invalid handling
    idle(); in_data = 14'h3FFF;
    tick("zinv");
    chk("zinv A", 32'(outA[13:0]), 0);
    chk("zinv B", 32'(outB[13:0]), 32'h3FFF);
    chk("zinv valid", 32'(validB[0]), 0);
    // counter saturation and clear
    idle(); clr_cnt = 1; tick("clr");
    idle(); stall_in = 1;
    for (int k = 0; k < 5; k++) tick("sat");
    chk("sat B", 32'(cntB), 3);
    chk("sat A", 32'(cntA), 5);
    clr_cnt = 1; tick("clrbub");
    chk("clrbub B", 32'(cntB), 0);
    // ordering error
    idle(); stall = 3'b100; tick("ord");
    chk("ord set", 32'(errA), 1);
    stall = 3'b000; tick("ord hold");
    chk("ord sticky", 32'(errA), 1);
    clr_cnt = 1; tick("ord clr");
    chk("ord cleared", 32'(errA), 0);
    // async reset mid-operation
    idle(); in_valid = 1; in_data = 14'h2AA;
    tick("pre1"); tick("pre2"); tick("pre3");
    #2 rst = 1;
    #1;
    chk("async data", 32'(outA), 0);
    chk("async valid", 32'(validA), 0);
    chk("async cnt", 32'(cntA), 0);
    modelReset();
    @(negedge clk); rst = 0;
    // random
    for (int k = 0; k < 400; k++) begin
      in_data = 14'($urandom);
      in_valid = 1'($urandom);
      stall_in = ($urandom_range(0, 3) == 0);
      for (int i = 0; i < 3; i++) begin
        stall[i] = ($urandom_range(0, 4) == 0);
        flush[i] = ($urandom_range(0, 9) == 0);
      end
      flush_all = ($urandom_range(0, 19) == 0);
      clr_cnt = ($urandom_range(0, 24) == 0);
      tick("rand");
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
